// File: rtl/video_frame_reader.sv
// Avalon-MM read master that streams a stored frame out of the SDRAM frame buffer in raster order.
// A credit-limited show-ahead FIFO decouples bus read latency from sink backpressure.
package video_frame_reader_pkg;
  typedef struct packed {
    logic [15:0] hc;
    logic [15:0] vc;
    logic        frame_start;
  } vga_fc_t;
endpackage

module video_frame_reader
  import video_frame_reader_pkg::*;
#(
  parameter int          AVS_DW     = 16,
  parameter int          AVS_AW     = 23,
  parameter int          RGB_SIZE   = 12,
  parameter int          H_DISPLAY  = 640,
  parameter int          V_DISPLAY  = 480,
  parameter int          FIFO_DEPTH = 8,
  parameter int unsigned FB_BASE    = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                enable,
  output logic                frame_done,
  output logic [AVS_AW-1:0]   avm_address,
  output logic                avm_read,
  input  logic                avm_waitrequest,
  input  logic [AVS_DW-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output vga_fc_t             snk_fc,
  output logic                snk_vld,
  output logic [RGB_SIZE-1:0] snk_rgb,
  input  logic                snk_rdy
);
  localparam int XW = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
  localparam int YW = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_DISPLAY - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_DISPLAY - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t              state_q;
  logic [XW-1:0]       rd_x_q, out_x_q;
  logic [YW-1:0]       rd_y_q, out_y_q;
  logic [AVS_AW-1:0]   avm_address_q;
  logic                avm_read_q, frame_done_q;
  logic [CW-1:0]       outst_q, outst_d, cnt_q, cnt_d;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [RGB_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic                accept, push, pop, rd_last, out_last, credit_ok;
  logic                unused_rd;

  assign unused_rd = ^avm_readdata;

  always_comb begin
    accept   = avm_read_q & ~avm_waitrequest;
    push     = avm_readdatavalid;
    pop      = snk_vld & snk_rdy;
    rd_last  = (rd_x_q == X_LAST) & (rd_y_q == Y_LAST);
    out_last = (out_x_q == X_LAST) & (out_y_q == Y_LAST);
    outst_d  = outst_q;
    if (accept & ~push)      outst_d = outst_q + 1'b1;
    else if (~accept & push) outst_d = outst_q - 1'b1;
    cnt_d = cnt_q;
    if (push & ~pop)      cnt_d = cnt_q + 1'b1;
    else if (~push & pop) cnt_d = cnt_q - 1'b1;
    // Credit is judged on next-cycle occupancy so a fresh request can never overrun the FIFO.
    credit_ok = ({1'b0, outst_d} + {1'b0, cnt_d}) < (CW+1)'(FIFO_DEPTH);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      avm_address_q <= '0;
      avm_read_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      outst_q       <= '0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      frame_done_q <= 1'b0;
      outst_q      <= outst_d;
      cnt_q        <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= avm_readdata[RGB_SIZE-1:0];
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (out_x_q == X_LAST) begin
          out_x_q <= '0;
          out_y_q <= (out_y_q == Y_LAST) ? '0 : out_y_q + 1'b1;
        end else begin
          out_x_q <= out_x_q + 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q       <= FETCH;
            rd_x_q        <= '0;
            rd_y_q        <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            avm_address_q <= AVS_AW'(FB_BASE);
            avm_read_q    <= credit_ok;
          end
        end
        FETCH: begin
          if (accept) begin
            avm_address_q <= avm_address_q + 1'b1;
            if (rd_x_q == X_LAST) begin
              rd_x_q <= '0;
              rd_y_q <= (rd_y_q == Y_LAST) ? '0 : rd_y_q + 1'b1;
            end else begin
              rd_x_q <= rd_x_q + 1'b1;
            end
          end
          if (accept && rd_last) begin
            state_q    <= DRAIN;
            avm_read_q <= 1'b0;
          end else if (!(avm_read_q && avm_waitrequest)) begin
            avm_read_q <= credit_ok;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign frame_done  = frame_done_q;
  assign snk_vld     = (cnt_q != '0);
  assign snk_rgb     = snk_vld ? mem_q[rd_ptr_q] : '0;
  assign snk_fc      = '{hc: 16'(out_x_q), vc: 16'(out_y_q),
                         frame_start: snk_vld & (out_x_q == '0) & (out_y_q == '0)};

  // The credit scheme guarantees read data never lands on a full FIFO that is not also popping.
  assert property (@(posedge sys_clk) disable iff (sys_rst)
    !(push && (cnt_q == CW'(FIFO_DEPTH)) && !pop));
endmodule

// File: tb/tb_video_frame_reader.sv
// Directed bench for video_frame_reader on a 4x2 frame at word 0x100, with a slave model whose
// memory word equals its address and whose stall, latency and sink-ready behaviour are programmable.
module tb_video_frame_reader;
  import video_frame_reader_pkg::*;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [11:0] rgb;
    logic [15:0] hc;
    logic [15:0] vc;
    logic        fs;
  } pix_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_done;
  logic [22:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  vga_fc_t     snk_fc;
  logic        snk_vld;
  logic [11:0] snk_rgb;
  logic        snk_rdy;

  video_frame_reader #(
    .AVS_DW(16), .AVS_AW(23), .RGB_SIZE(12), .H_DISPLAY(H), .V_DISPLAY(V),
    .FIFO_DEPTH(DEPTH), .FB_BASE(32'h100)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .frame_done(frame_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .snk_fc(snk_fc), .snk_vld(snk_vld), .snk_rgb(snk_rgb), .snk_rdy(snk_rdy)
  );

  always #5 sys_clk = ~sys_clk;

  int          errors = 0;
  int          checks = 0;
  int          lat_min = 1, lat_max = 1, stall_req = 0;
  logic [22:0] stall_addr = 23'h102;
  logic        rdy_force = 1'b1, rdy_rand = 1'b0;

  logic [22:0] addr_q[$];
  pix_t        pix_q[$];
  logic [22:0] resp_addr[$];
  int          resp_due[$];
  int          cyc = 0, stall_used = 0, stall_cycles = 0, stall_viol = 0, hold_viol = 0;
  int          fd_cnt = 0, fd_good = 0, occ = 0, max_occ = 0;
  logic        prev_stall = 1'b0, prev_hold = 1'b0, prev_last_pop = 1'b0, acc, popv;
  logic [22:0] prev_addr = '0;
  logic [11:0] prev_rgb = '0;
  vga_fc_t     prev_fc = '0;

  // Slave model and stream recorder; acts on the falling edge for the following rising edge.
  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst) begin
      resp_addr.delete();
      resp_due.delete();
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      avm_waitrequest = 1'b0;
      snk_rdy = rdy_force;
      occ = 0;
      prev_stall = 1'b0;
      prev_hold = 1'b0;
      prev_last_pop = 1'b0;
    end else begin
      snk_rdy = rdy_rand ? ($urandom_range(1, 0) == 1) : rdy_force;
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = 16'(resp_addr[0]);
        void'(resp_addr.pop_front());
        void'(resp_due.pop_front());
      end
      avm_waitrequest = avm_read && (avm_address == stall_addr) && (stall_used < stall_req);
      if (avm_waitrequest) begin
        stall_used++;
        stall_cycles++;
      end
      if (prev_stall && !(avm_read && avm_address == prev_addr)) stall_viol++;
      if (prev_hold && (snk_rgb !== prev_rgb || snk_fc !== prev_fc)) hold_viol++;
      acc  = avm_read && !avm_waitrequest;
      popv = snk_vld && snk_rdy;
      if (acc) begin
        addr_q.push_back(avm_address);
        resp_addr.push_back(avm_address);
        resp_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
      if (popv) pix_q.push_back('{rgb: snk_rgb, hc: snk_fc.hc, vc: snk_fc.vc, fs: snk_fc.frame_start});
      if (frame_done) begin
        fd_cnt++;
        if (prev_last_pop) fd_good++;
      end
      prev_last_pop = popv && snk_fc.hc == 16'(H - 1) && snk_fc.vc == 16'(V - 1);
      occ = occ + int'(acc) - int'(popv);
      if (occ > max_occ) max_occ = occ;
      prev_stall = avm_read && avm_waitrequest;
      prev_addr = avm_address;
      prev_hold = snk_vld && !snk_rdy;
      prev_rgb = snk_rgb;
      prev_fc = snk_fc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_fd(input int target, input string tag);
    int n = 0;
    while (fd_cnt < target && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, 32'(fd_cnt >= target), 32'd1);
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    step(1);
    enable = 1'b0;
  endtask

  task automatic check_frames(input int a0, input int p0, input int nf, input string tag);
    check({tag, "_addr_count"}, 32'(addr_q.size() - a0), 32'(N * nf));
    check({tag, "_pix_count"}, 32'(pix_q.size() - p0), 32'(N * nf));
    for (int i = 0; i < N * nf; i++) begin
      int k;
      logic [22:0] a;
      pix_t p;
      k = i % N;
      a = (a0 + i < addr_q.size()) ? addr_q[a0 + i] : '1;
      p = (p0 + i < pix_q.size()) ? pix_q[p0 + i] : '1;
      check({tag, "_addr"}, 32'(a), 32'h100 + 32'(k));
      check({tag, "_rgb"}, 32'(p.rgb), 32'h100 + 32'(k));
      check({tag, "_hc"}, 32'(p.hc), 32'(k % H));
      check({tag, "_vc"}, 32'(p.vc), 32'(k / H));
      check({tag, "_fs"}, 32'(p.fs), 32'(k == 0));
    end
  endtask

  initial begin
    int a0, p0, f0, g0, s0, n;
    step(3);
    check("rst_read", 32'(avm_read), 0);
    check("rst_addr", 32'(avm_address), 0);
    check("rst_vld", 32'(snk_vld), 0);
    check("rst_rgb", 32'(snk_rgb), 0);
    check("rst_fc", 32'(snk_fc), 0);
    check("rst_done", 32'(frame_done), 0);
    sys_rst = 1'b0;
    step(2);

    // single enable pulse, zero-wait slave, latency 1, sink always ready
    a0 = addr_q.size(); p0 = pix_q.size(); f0 = fd_cnt; g0 = fd_good;
    pulse_enable();
    wait_fd(f0 + 1, "t1_timeout");
    step(10);
    check("t1_fd_count", 32'(fd_cnt - f0), 1);
    check("t1_fd_after_last", 32'(fd_good - g0), 1);
    check("t1_idle_read", 32'(avm_read), 0);
    check_frames(a0, p0, 1, "t1");

    // three wait states on 0x102
    a0 = addr_q.size(); p0 = pix_q.size(); f0 = fd_cnt; s0 = stall_cycles;
    stall_req = 3;
    pulse_enable();
    wait_fd(f0 + 1, "t2_timeout");
    step(10);
    check("t2_stall_cycles", 32'(stall_cycles - s0), 3);
    check("t2_stall_hold", 32'(stall_viol), 0);
    check_frames(a0, p0, 1, "t2");

    // sink stalled for 20 cycles: credit limits the fetch to 4 words
    a0 = addr_q.size(); p0 = pix_q.size(); f0 = fd_cnt;
    rdy_force = 1'b0;
    pulse_enable();
    step(20);
    check("t3_read_dropped", 32'(avm_read), 0);
    check("t3_issued", 32'(addr_q.size() - a0), 32'(DEPTH));
    check("t3_vld", 32'(snk_vld), 1);
    check("t3_rgb_held", 32'(snk_rgb), 32'h100);
    check("t3_hc_held", 32'(snk_fc.hc), 0);
    check("t3_fs_held", 32'(snk_fc.frame_start), 1);
    check("t3_hold", 32'(hold_viol), 0);
    rdy_force = 1'b1;
    wait_fd(f0 + 1, "t3_timeout");
    step(10);
    check_frames(a0, p0, 1, "t3");

    // random latency 1..5 and random sink ready
    a0 = addr_q.size(); p0 = pix_q.size(); f0 = fd_cnt;
    lat_max = 5;
    rdy_rand = 1'b1;
    pulse_enable();
    wait_fd(f0 + 1, "t4_timeout");
    step(10);
    check_frames(a0, p0, 1, "t4");
    lat_max = 1;
    rdy_rand = 1'b0;
    step(2);

    // enable held across a frame boundary, dropped early in the second frame
    a0 = addr_q.size(); p0 = pix_q.size(); f0 = fd_cnt; g0 = fd_good;
    enable = 1'b1;
    wait_fd(f0 + 1, "t5_first_timeout");
    step(1);
    enable = 1'b0;
    wait_fd(f0 + 2, "t5_second_timeout");
    step(10);
    check("t5_fd_count", 32'(fd_cnt - f0), 2);
    check("t5_fd_after_last", 32'(fd_good - g0), 2);
    check("t5_idle_read", 32'(avm_read), 0);
    check_frames(a0, p0, 2, "t5");

    // reset after three pixels, then a clean restart
    p0 = pix_q.size();
    pulse_enable();
    n = 0;
    while (pix_q.size() - p0 < 3 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("t6_pix_timeout", 32'(pix_q.size() - p0 >= 3), 1);
    step(1);
    sys_rst = 1'b1;
    #1;
    check("t6_rst_read", 32'(avm_read), 0);
    check("t6_rst_addr", 32'(avm_address), 0);
    check("t6_rst_vld", 32'(snk_vld), 0);
    check("t6_rst_rgb", 32'(snk_rgb), 0);
    check("t6_rst_fc", 32'(snk_fc), 0);
    check("t6_rst_done", 32'(frame_done), 0);
    step(2);
    sys_rst = 1'b0;
    step(2);
    a0 = addr_q.size(); p0 = pix_q.size(); f0 = fd_cnt;
    pulse_enable();
    wait_fd(f0 + 1, "t6_timeout");
    step(10);
    check_frames(a0, p0, 1, "t6");

    check("max_occupancy_ok", 32'(max_occ <= DEPTH), 1);
    check("hold_total", 32'(hold_viol), 0);
    check("stall_total", 32'(stall_viol), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
